// File: rtl/asap_pkg.sv
// Shared types and constants for the ASAP CPU program loader.
package asap_pkg;

    localparam int unsigned ASAP_INSTR_W        = 16;
    localparam int unsigned ASAP_BYTE_W         = 8;
    localparam int unsigned ASAP_LEN_ZERO_WORDS = 256;
    localparam int unsigned ASAP_WCNT_W         = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_LO,
        ST_HI,
        ST_CSUM,
        ST_RUN,
        ST_ERROR
    } asap_loader_state_t;

endpackage

// File: rtl/asap_edge_sync.sv
// Two-flop synchronizer with rising-edge detect for an asynchronous pin.
module asap_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise_c
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    // Decoded from flops only, so the consumer acts on the third edge that samples the pin high.
    assign o_rise_c = r_sync & ~r_prev;

endmodule

// File: rtl/asap_prog_loader.sv
// Byte-serial, length-prefixed program loader for the ASAP core instruction memory.
// Optional trailing checksum byte enabled by defining ASAP_LOADER_CHECKSUM_EN.
module asap_prog_loader
    import asap_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic [ASAP_BYTE_W-1:0]  in_data,
    input  logic                    in_strobe,
    input  logic                    load_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [ASAP_INSTR_W-1:0] mem_wdata,
    output logic                    core_run,
    output logic                    busy,
    output logic                    err
);

    localparam int unsigned CAP_WORDS = 32'd1 << ADDR_W;

    asap_loader_state_t r_state, w_state_nxt;

    logic                    r_mem_we,    w_we_nxt;
    logic [ADDR_W-1:0]       r_mem_addr,  w_addr_nxt;
    logic [ASAP_INSTR_W-1:0] r_mem_wdata, w_wdata_nxt;
    logic                    r_core_run,  w_run_nxt;
    logic                    r_busy,      w_busy_nxt;
    logic                    r_err,       w_err_nxt;
    logic [ASAP_BYTE_W-1:0]  r_lo,        w_lo_nxt;
    logic [ASAP_WCNT_W-1:0]  r_left,      w_left_nxt;
    logic [ASAP_WCNT_W-1:0]  w_len_words;
    logic                    w_strb_rise;
    logic                    w_load_rise;
`ifdef ASAP_LOADER_CHECKSUM_EN
    logic [ASAP_BYTE_W-1:0]  r_csum,      w_csum_nxt;
    logic [ASAP_BYTE_W-1:0]  w_csum_sum;
`endif

    asap_edge_sync u_strobe_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_async  (in_strobe),
        .o_rise_c (w_strb_rise)
    );

    asap_edge_sync u_load_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_async  (load_req),
        .o_rise_c (w_load_rise)
    );

    // A zero length byte encodes a full 256-word program.
    assign w_len_words = (in_data == '0) ? ASAP_WCNT_W'(ASAP_LEN_ZERO_WORDS)
                                         : ASAP_WCNT_W'(in_data);
`ifdef ASAP_LOADER_CHECKSUM_EN
    assign w_csum_sum  = r_csum + in_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = r_mem_we ? r_mem_addr + ADDR_W'(1) : r_mem_addr;
        w_wdata_nxt = r_mem_wdata;
        w_run_nxt   = r_core_run;
        w_err_nxt   = r_err;
        w_lo_nxt    = r_lo;
        w_left_nxt  = r_left;
`ifdef ASAP_LOADER_CHECKSUM_EN
        w_csum_nxt  = r_csum;
`endif
        // A load request outranks a byte strobe arriving in the same cycle.
        if (ena && w_load_rise) begin
            w_state_nxt = ST_LEN;
            w_err_nxt   = 1'b0;
            w_run_nxt   = 1'b0;
            w_addr_nxt  = '0;
            w_left_nxt  = '0;
`ifdef ASAP_LOADER_CHECKSUM_EN
            w_csum_nxt  = '0;
`endif
        end else if (ena && w_strb_rise) begin
            case (r_state)
                ST_LEN: begin
`ifdef ASAP_LOADER_CHECKSUM_EN
                    w_csum_nxt = w_csum_sum;
`endif
                    if (32'(w_len_words) > CAP_WORDS) begin
                        w_state_nxt = ST_ERROR;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_left_nxt  = w_len_words;
                        w_state_nxt = ST_LO;
                    end
                end
                ST_LO: begin
`ifdef ASAP_LOADER_CHECKSUM_EN
                    w_csum_nxt  = w_csum_sum;
`endif
                    w_lo_nxt    = in_data;
                    w_state_nxt = ST_HI;
                end
                ST_HI: begin
`ifdef ASAP_LOADER_CHECKSUM_EN
                    w_csum_nxt  = w_csum_sum;
`endif
                    w_we_nxt    = 1'b1;
                    w_wdata_nxt = {in_data, r_lo};
                    w_left_nxt  = r_left - ASAP_WCNT_W'(1);
                    if (r_left == ASAP_WCNT_W'(1)) begin
`ifdef ASAP_LOADER_CHECKSUM_EN
                        w_state_nxt = ST_CSUM;
`else
                        w_state_nxt = ST_RUN;
                        w_run_nxt   = 1'b1;
`endif
                    end else begin
                        w_state_nxt = ST_LO;
                    end
                end
`ifdef ASAP_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    w_csum_nxt = w_csum_sum;
                    if (w_csum_sum == '0) begin
                        w_state_nxt = ST_RUN;
                        w_run_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = ST_ERROR;
                        w_err_nxt   = 1'b1;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
        w_busy_nxt = (w_state_nxt == ST_LEN) || (w_state_nxt == ST_LO) ||
                     (w_state_nxt == ST_HI)  || (w_state_nxt == ST_CSUM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_core_run  <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_lo        <= '0;
            r_left      <= '0;
`ifdef ASAP_LOADER_CHECKSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            r_mem_we    <= w_we_nxt;
            r_mem_addr  <= w_addr_nxt;
            r_mem_wdata <= w_wdata_nxt;
            r_core_run  <= w_run_nxt;
            r_busy      <= w_busy_nxt;
            r_err       <= w_err_nxt;
            r_lo        <= w_lo_nxt;
            r_left      <= w_left_nxt;
`ifdef ASAP_LOADER_CHECKSUM_EN
            r_csum      <= w_csum_nxt;
`endif
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign core_run  = r_core_run;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule

// File: tb/tb_asap_prog_loader.sv
// Scoreboard bench for asap_prog_loader: an 8-bit and a 4-bit address instance share one pin bus.
`timescale 1ns/1ps
module tb_asap_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_strobe = 1'b0;
    logic        load_req = 1'b0;

    logic        we8, run8, busy8, err8;
    logic [7:0]  addr8;
    logic [15:0] wd8;
    logic        we4, run4, busy4, err4;
    logic [3:0]  addr4;
    logic [15:0] wd4;

    always #5 clk = ~clk;

    asap_prog_loader #(.ADDR_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_data(in_data),
        .in_strobe(in_strobe), .load_req(load_req), .mem_we(we8),
        .mem_addr(addr8), .mem_wdata(wd8), .core_run(run8),
        .busy(busy8), .err(err8)
    );

    asap_prog_loader #(.ADDR_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_data(in_data),
        .in_strobe(in_strobe), .load_req(load_req), .mem_we(we4),
        .mem_addr(addr4), .mem_wdata(wd4), .core_run(run4),
        .busy(busy4), .err(err4)
    );

`ifdef ASAP_LOADER_CHECKSUM_EN
    localparam int RUN_AT_HI = 0;
`else
    localparam int RUN_AT_HI = 1;
`endif

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t        q8[$];
    wr_t        q4[$];
    wr_t        e8, e4;
    logic [7:0] prog[$];
    int         n_pass = 0;
    int         n_total = 0;
    int         exp_run[2], exp_err[2], exp_busy[2], exp_addr[2];
    bit         prev8 = 1'b0;
    bit         prev4 = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Reference: what a loader with capacity `cap` does with the bytes in prog after a load request.
    task automatic predict(input int which);
        int  cap, n, w, done, sum;
        wr_t e;
        cap = (which == 0) ? 256 : 16;
        n = prog.size();
        exp_run[which]  = 0;
        exp_err[which]  = 0;
        exp_busy[which] = 1;
        exp_addr[which] = 0;
        if (n == 0) return;
        w = (prog[0] == 8'h00) ? 256 : int'(prog[0]);
        if (w > cap) begin
            exp_err[which]  = 1;
            exp_busy[which] = 0;
            return;
        end
        done = 0;
        for (int i = 0; i < w; i++) begin
            if (2 * i + 2 < n) begin
                e.addr = i % cap;
                e.data = {prog[2*i+2], prog[2*i+1]};
                if (which == 0) q8.push_back(e);
                else q4.push_back(e);
                done++;
            end
        end
        exp_addr[which] = done % cap;
`ifdef ASAP_LOADER_CHECKSUM_EN
        if (n >= 2 * w + 2) begin
            sum = 0;
            for (int i = 0; i < 2 * w + 2; i++) sum += int'(prog[i]);
            if (sum % 256 == 0) exp_run[which] = 1;
            else exp_err[which] = 1;
            exp_busy[which] = 0;
        end
`else
        sum = 0;
        if (n >= 2 * w + 1) begin
            exp_run[which]  = 1;
            exp_busy[which] = 0;
        end
`endif
    endtask

    task automatic add_csum(input bit corrupt);
        int s;
        s = 0;
        foreach (prog[i]) s += int'(prog[i]);
        prog.push_back(8'((256 - (s % 256)) + (corrupt ? 1 : 0)));
    endtask

    task automatic issue_load(input bit chk_lat);
        @(posedge clk); #1 load_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (chk_lat) chk("load_lat_edge2_busy", busy8, 0);
        @(posedge clk); #1;
        if (chk_lat) chk("load_lat_edge3_busy", busy8, 1);
        @(posedge clk); #1 load_req = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit chk_last);
        @(posedge clk); #1 in_data = b; in_strobe = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (chk_last) chk("we_edge2", we8, 0);
        @(posedge clk); #1;
        if (chk_last) begin
            chk("we_edge3", we8, 1);
            chk("run_with_last_we", run8, RUN_AT_HI);
        end
        @(posedge clk); #1 in_strobe = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic check_status(input string tag);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_run8"},  run8,  exp_run[0]);
        chk({tag, "_err8"},  err8,  exp_err[0]);
        chk({tag, "_busy8"}, busy8, exp_busy[0]);
        chk({tag, "_addr8"}, addr8, exp_addr[0]);
        chk({tag, "_pend8"}, q8.size(), 0);
        chk({tag, "_run4"},  run4,  exp_run[1]);
        chk({tag, "_err4"},  err4,  exp_err[1]);
        chk({tag, "_busy4"}, busy4, exp_busy[1]);
        chk({tag, "_addr4"}, addr4, exp_addr[1]);
        chk({tag, "_pend4"}, q4.size(), 0);
    endtask

    task automatic run_prog(input string tag);
        predict(0);
        predict(1);
        issue_load(1'b0);
        foreach (prog[i]) send_byte(prog[i], 1'b0);
        check_status(tag);
    endtask

    // Write monitor: every mem_we pulse must match the oldest expected write and last one cycle.
    always @(negedge clk) begin
        if (rst_n && we8) begin
            chk("we8_single_cycle", prev8, 0);
            if (q8.size() == 0) chk("wr8_unexpected", 1, 0);
            else begin
                e8 = q8.pop_front();
                chk("wr8_addr", addr8, e8.addr);
                chk("wr8_data", wd8, e8.data);
            end
        end
        prev8 = we8;
        if (rst_n && we4) begin
            chk("we4_single_cycle", prev4, 0);
            if (q4.size() == 0) chk("wr4_unexpected", 1, 0);
            else begin
                e4 = q4.pop_front();
                chk("wr4_addr", addr4, e4.addr);
                chk("wr4_data", wd4, e4.data);
            end
        end
        prev4 = we4;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs8", {we8, addr8, wd8, run8, busy8, err8}, 0);
        chk("reset_outputs4", {we4, addr4, wd4, run4, busy4, err4}, 0);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic two-word load with edge-accurate latency checks.
        prog = '{8'h02, 8'h34, 8'h12, 8'hCD, 8'hAB};
        predict(0);
        predict(1);
        issue_load(1'b1);
        for (int i = 0; i < 4; i++) send_byte(prog[i], 1'b0);
        send_byte(prog[4], 1'b1);
        check_status("basic");

        // Checksum good then bad (trailing byte when the checksum is not built).
        prog = '{8'h01, 8'h34, 8'h12, 8'hB9};
        run_prog("csum_good");
        prog = '{8'h01, 8'h34, 8'h12, 8'hB8};
        run_prog("csum_bad");

        // Abort after 3 of 5 bytes, then a fresh load.
        prog = '{8'h02, 8'hAA, 8'hBB};
        run_prog("abort_part");
        prog = '{8'h01, 8'h11, 8'h22};
        add_csum(1'b0);
        run_prog("abort_fresh");

        // Strobe and load edge together: the byte is discarded.
        prog = '{8'h03, 8'h01, 8'h02};
        run_prog("collide_pre");
        @(posedge clk); #1 in_data = 8'h77; in_strobe = 1'b1; load_req = 1'b1;
        repeat (4) @(posedge clk);
        #1 in_strobe = 1'b0; load_req = 1'b0;
        repeat (4) @(posedge clk);
        prog = '{8'h02, 8'h5A, 8'hA5, 8'h3C, 8'hC3};
        add_csum(1'b0);
        predict(0);
        predict(1);
        foreach (prog[i]) send_byte(prog[i], 1'b0);
        check_status("collide");

        // Enable gating: a strobe while ena=0 is dropped.
        prog = '{8'h02, 8'h10, 8'h20, 8'h30, 8'h40};
        add_csum(1'b0);
        predict(0);
        predict(1);
        issue_load(1'b0);
        send_byte(prog[0], 1'b0);
        #1 ena = 1'b0;
        send_byte(8'hEE, 1'b0);
        #1 ena = 1'b1;
        for (int i = 1; i < prog.size(); i++) send_byte(prog[i], 1'b0);
        check_status("gating");

        // Full capacity for ADDR_W=8 (address wraps), over capacity for ADDR_W=4.
        prog = '{8'h00};
        repeat (512) prog.push_back(8'($urandom));
        add_csum(1'b0);
        run_prog("full256");

        for (int it = 0; it < 30; it++) begin
            int len;
            len = int'($urandom_range(1, 24));
            prog = '{8'(len)};
            repeat (2 * len) prog.push_back(8'($urandom));
            add_csum($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) begin
                int k;
                k = int'($urandom_range(1, prog.size() - 1));
                while (prog.size() > k) void'(prog.pop_back());
            end
            run_prog("rand");
        end

        // Reset in the middle of a load.
        prog = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h44};
        run_prog("pre_reset");
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("midload_reset8", {we8, addr8, wd8, run8, busy8, err8}, 0);
        chk("midload_reset4", {we4, addr4, wd4, run4, busy4, err4}, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        send_byte(8'h02, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        #1;
        chk("idle_busy8", busy8, 0);
        chk("idle_run8", run8, 0);
        chk("idle_addr8", addr8, 0);
        chk("idle_busy4", busy4, 0);

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
